pattern_request_scheduler: RTL
==============================

# pattern_request_scheduler

Shares the single tagged memory request port of the pattern decoder among its four request streams: header, code table, Huffman stream and argument stream. Each stream gets one issue slot per cycle, gated by per-tag credits so the return-side FIFOs can never overflow. The block also tracks in-flight requests per tag and replaces ad-hoc issue gating in the decoder front end. It sits between the decoder's address generators and the memory request interface.

## Interface
- ADDR_WIDTH, 48, request address width
- TAG_COUNT, 4, number of requesters/tags
- TAG_WIDTH, log2(TAG_COUNT), tag width
- CREDITS, 4, return-buffer slots (64-bit words) per tag
- PRIORITY_TAGS, 2, tags 0..PRIORITY_TAGS-1 are fixed priority
- MAX_OUTSTANDING, 64, global cap on accepted-but-unanswered requests

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ch_valid  in  TAG_COUNT  requester i has an address pending
- ch_addr  in  TAG_COUNT*ADDR_WIDTH  address of requester i, slice i
- ch_ready  out  TAG_COUNT  combinational one-hot grant; requester i advances when high
- credit_return  in  TAG_COUNT  pulse: consumer freed one word of tag i
- push  in  1  memory response valid
- push_tag  in  TAG_WIDTH  tag of response
- req  out  1  request valid (registered)
- req_tag  out  TAG_WIDTH  request tag (registered)
- req_addr  out  ADDR_WIDTH  request address (registered)
- req_stall  in  1  memory cannot accept this cycle
- idle  out  1  no held request and zero outstanding
- err  out  1  sticky protocol error

## Operation
- Output stage: one-entry register {req, req_tag, req_addr}. It is accepted in a cycle with req && !req_stall. It may load a new grant when !req or when it is being accepted that cycle.
- Eligible(i) = ch_valid[i] && credit[i] != 0 && outstanding_total + held < MAX_OUTSTANDING, where held = req.
- Arbitration runs only in load cycles:
  - The lowest-index eligible tag below PRIORITY_TAGS wins.
  - Otherwise, round-robin among the remaining tags, starting at rr_ptr+1.
  - rr_ptr updates only on a round-robin grant.
- Grant(i): ch_ready[i]=1; credit[i] decrements; ch_addr slice i is captured into req_addr; req_tag=i; req=1.
- No eligible tag in a load cycle: req clears to 0 after acceptance.
- Credits:
  - Reset value is CREDITS.
  - A grant and a credit_return on the same tag in the same cycle net to zero.
  - credit_return on a tag already at CREDITS: counter is unchanged and err is set.
- Outstanding:
  - Per-tag and total counters increment on acceptance and decrement on push for push_tag.
  - Simultaneous accept and push of the same tag nets to zero.
  - push to a tag with zero outstanding: counter is unchanged and err is set.
- idle = !req && outstanding_total == 0.
- Reset (any time, including mid-burst):
  - req=0, req_tag=0, req_addr=0, ch_ready=0.
  - Credits = CREDITS, outstanding = 0, rr_ptr = TAG_COUNT-1, err=0, idle=1.

## Timing
- Grant latency: ch_valid high in cycle t with the stage free gives ch_ready in cycle t and req in t+1.
- Throughput: one request per cycle while req_stall is low.
- Stall: while req && req_stall, req, req_tag and req_addr hold stable and ch_ready stays 0.
- Credit visibility:
  - A credit_return in cycle t makes the tag eligible in t+1.
  - A credit consumed in cycle t is visible in eligibility at t+1.
- Counters are clamped to width log2(CREDITS)+1 and log2(MAX_OUTSTANDING)+1; they never wrap.
- err is sticky until reset.

## Structure
- Shared package pattern_decoder_pkg holds:
  - TAG_HEADER=0, TAG_CODES=1, TAG_HUFFMAN=2, TAG_ARGUMENT=3
  - TAG_WIDTH and the default CREDITS
  - the log2 function from log2.vh
- One sub-module, rr_arbiter (parameter N; inputs request vector and pointer; output one-hot grant), is instantiated for tags PRIORITY_TAGS..TAG_COUNT-1.

## Test plan
- Reset, then ch_valid=4'b0001 with addr 0x1000, no stall:
  - ch_ready=0001 in the same cycle.
  - Next cycle: req=1, req_tag=0, req_addr=0x1000.
  - After 4 grants without credit_return, tag 0 is no longer granted.
- ch_valid=4'b1111, no stall, credits plentiful: order is 0,1 while they are valid; with 0/1 dropped, grants alternate 2,3,2,3.
- req_stall held 5 cycles mid-stream: outputs are stable, ch_ready=0; the first cycle after stall release accepts, with no duplicate or dropped request.
- Issue 3 on tag 2, then 3 pushes with push_tag=2: idle goes 0, then 1 the cycle after the last push; a 4th push sets err.
- credit_return[3] at count CREDITS sets err; a simultaneous grant and credit_return on tag 3 leaves the credit unchanged.
- Drive rst low mid-burst with req=1: outputs clear asynchronously; after release, credits=4 and idle=1.

Source files
------------

// File: rtl/pattern_decoder_pkg.sv
// Shared definitions for the pattern decoder request path: tag names,
// default widths/credit depth and a ceiling-log2 helper.
package pattern_decoder_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int TAG_COUNT_DEFAULT = 4;
  localparam int TAG_WIDTH_DEFAULT = log2(TAG_COUNT_DEFAULT);
  localparam int CREDITS_DEFAULT   = 4;

  // Request stream identifiers; the value is the tag carried on the port.
  typedef enum logic [TAG_WIDTH_DEFAULT-1:0] {
    TAG_HEADER   = 2'd0,
    TAG_CODES    = 2'd1,
    TAG_HUFFMAN  = 2'd2,
    TAG_ARGUMENT = 2'd3
  } tag_e;

endpackage

// File: rtl/pattern_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found after ptr,
// wrapping around, as a one-hot vector. Purely combinational.
module rr_arbiter
  import pattern_decoder_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? log2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // Scan offsets 1..N from the pointer and take the first active request.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && request[j] && (j == ((int'(ptr) + k) % N))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pattern_request_scheduler.sv
// Shares one tagged memory request port among the decoder's request
// streams. Per-tag credits protect the return FIFOs, per-tag and total
// in-flight counters bound outstanding traffic, and a one-entry output
// register holds the request until the memory accepts it.
module pattern_request_scheduler
  import pattern_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 48,
  parameter int TAG_COUNT       = 4,
  parameter int TAG_WIDTH       = log2(TAG_COUNT),
  parameter int CREDITS         = CREDITS_DEFAULT,
  parameter int PRIORITY_TAGS   = 2,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TAG_COUNT-1:0]            ch_valid,
  input  logic [TAG_COUNT*ADDR_WIDTH-1:0] ch_addr,
  output logic [TAG_COUNT-1:0]            ch_ready,
  input  logic [TAG_COUNT-1:0]            credit_return,
  input  logic                            push,
  input  logic [TAG_WIDTH-1:0]            push_tag,
  output logic                            req,
  output logic [TAG_WIDTH-1:0]            req_tag,
  output logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic                            req_stall,
  output logic                            idle,
  output logic                            err
);

  localparam int CW    = log2(CREDITS) + 1;
  localparam int OW    = log2(MAX_OUTSTANDING) + 1;
  localparam int RR_N  = TAG_COUNT - PRIORITY_TAGS;
  localparam int RR_PW = (RR_N > 1) ? log2(RR_N) : 1;

  logic                  req_reg;
  logic [TAG_WIDTH-1:0]  req_tag_reg;
  logic [ADDR_WIDTH-1:0] req_addr_reg;
  logic [TAG_WIDTH-1:0]  rr_ptr_reg;
  logic [OW-1:0]         total_reg;
  logic                  err_reg;

  logic                     load;
  logic                     accept;
  logic                     cap_ok;
  logic [OW:0]              inflight;
  logic [TAG_COUNT-1:0]     credit_nz;
  logic [TAG_COUNT-1:0]     eligible;
  logic [PRIORITY_TAGS-1:0] prio_grant;
  logic [RR_N-1:0]          rr_grant;
  logic [RR_PW-1:0]         rr_ptr_local;
  logic [TAG_COUNT-1:0]     grant;
  logic [TAG_WIDTH-1:0]     grant_tag;
  logic [ADDR_WIDTH-1:0]    grant_addr;
  logic                     rr_used;
  logic [TAG_COUNT-1:0]     credit_overflow;
  logic [TAG_COUNT-1:0]     push_bad;
  logic                     legal_push;

  // The output register is free when empty or being drained this cycle.
  assign accept = req_reg && !req_stall;
  assign load   = !req_reg || !req_stall;

  // The held request counts against the global cap before it is accepted.
  assign inflight = {1'b0, total_reg} + (OW+1)'(req_reg);
  assign cap_ok   = inflight < (OW+1)'(MAX_OUTSTANDING);

  genvar gi;
  generate
    for (gi = 0; gi < TAG_COUNT; gi++) begin : g_elig
      assign eligible[gi] = ch_valid[gi] && credit_nz[gi] && cap_ok;
    end
  endgenerate

  // Fixed priority: lowest eligible index among the priority tags.
  always_comb begin
    logic found;
    prio_grant = '0;
    found      = 1'b0;
    for (int i = 0; i < PRIORITY_TAGS; i++) begin
      if (!found && eligible[i]) begin
        prio_grant[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // rr_ptr holds a global tag index that is always in the round-robin range.
  assign rr_ptr_local = RR_PW'(rr_ptr_reg - TAG_WIDTH'(PRIORITY_TAGS));

  rr_arbiter #(
    .N  (RR_N),
    .PW (RR_PW)
  ) u_rr_arbiter (
    .request (eligible[TAG_COUNT-1:PRIORITY_TAGS]),
    .ptr     (rr_ptr_local),
    .grant   (rr_grant)
  );

  // Final one-hot grant; suppressed outside load cycles and while in reset.
  always_comb begin
    grant = '0;
    if (rst && load) begin
      if (|prio_grant) grant = {{RR_N{1'b0}}, prio_grant};
      else             grant = {rr_grant, {PRIORITY_TAGS{1'b0}}};
    end
  end

  assign rr_used  = rst && load && !(|prio_grant) && (|rr_grant);
  assign ch_ready = grant;

  // Encode the granted tag and select its address slice.
  always_comb begin
    grant_tag  = '0;
    grant_addr = '0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (grant[i]) begin
        grant_tag  = TAG_WIDTH'(i);
        grant_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  generate
    for (gi = 0; gi < TAG_COUNT; gi++) begin : g_tag
      logic [CW-1:0] credit_reg;
      logic [OW-1:0] out_reg;
      logic          take;
      logic          give;
      logic          acc_hit;
      logic          push_hit;

      assign take     = grant[gi];
      assign give     = credit_return[gi];
      assign acc_hit  = accept && (req_tag_reg == TAG_WIDTH'(gi));
      assign push_hit = push && (push_tag == TAG_WIDTH'(gi));

      assign credit_nz[gi]       = (credit_reg != '0);
      assign credit_overflow[gi] = give && !take && (credit_reg == CW'(CREDITS));
      assign push_bad[gi]        = push_hit && !acc_hit && (out_reg == '0);

      // Credit counter: grant consumes, credit_return refunds, never past CREDITS.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          credit_reg <= CW'(CREDITS);
        end else if (give && !take) begin
          if (credit_reg != CW'(CREDITS)) credit_reg <= credit_reg + 1'b1;
        end else if (take && !give) begin
          credit_reg <= credit_reg - 1'b1;
        end
      end

      // Per-tag in-flight count: acceptance adds, a response removes.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_reg <= '0;
        end else if (acc_hit && !push_hit) begin
          if (out_reg != OW'(MAX_OUTSTANDING)) out_reg <= out_reg + 1'b1;
        end else if (push_hit && !acc_hit && (out_reg != '0)) begin
          out_reg <= out_reg - 1'b1;
        end
      end
    end
  endgenerate

  assign legal_push = push && !(|push_bad);

  // Global in-flight count; a response to an empty tag is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_reg <= '0;
    end else if (accept && !legal_push) begin
      if (total_reg != OW'(MAX_OUTSTANDING)) total_reg <= total_reg + 1'b1;
    end else if (legal_push && !accept && (total_reg != '0)) begin
      total_reg <= total_reg - 1'b1;
    end
  end

  // Output stage: load a new grant (or empty) whenever the stage is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_reg      <= 1'b0;
      req_tag_reg  <= '0;
      req_addr_reg <= '0;
    end else if (load) begin
      req_reg <= |grant;
      if (|grant) begin
        req_tag_reg  <= grant_tag;
        req_addr_reg <= grant_addr;
      end
    end
  end

  // Round-robin pointer follows the last round-robin winner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rr_ptr_reg <= TAG_WIDTH'(TAG_COUNT - 1);
    else if (rr_used) rr_ptr_reg <= grant_tag;
  end

  // Sticky protocol error: credit overflow or response with nothing in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_reg <= 1'b0;
    else      err_reg <= err_reg | (|credit_overflow) | (|push_bad);
  end

  assign req      = req_reg;
  assign req_tag  = req_tag_reg;
  assign req_addr = req_addr_reg;
  assign idle     = !req_reg && (total_reg == '0);
  assign err      = err_reg;

endmodule
